onchip_mem_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single-port, 32-bit on-chip RAM (51200 words, 1-cycle read latency) between two Avalon-MM requesters. Sits between the masters and the RAM port in the Nios II system. Presents one pipelined slave port per master with `waitrequest` and `readdatavalid`. Drives the RAM's address, byteenable, chipselect, write and clken inputs, and routes the returning `readdata` to its owner.

---
 rtl/onchip_mem_arb_pkg.sv | 19 +
 rtl/onchip_mem_arbiter_if.sv | 25 ++
 rtl/onchip_mem_rd_tracker.sv | 31 +++
 rtl/onchip_mem_arbiter.sv | 111 +++++++++++
 tb/tb_onchip_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and default sizes for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 16;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 51200;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oor;
    } rd_entry_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Pipelined Avalon-MM requester port (one per master) with waitrequest/readdatavalid.
interface onchip_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = DATA_W / 8
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_rd_tracker.sv
// RD_LAT-stage shift register of outstanding reads; tail lines up with RAM q.
module onchip_mem_rd_tracker
    import onchip_mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  rd_entry_t push,
    output rd_entry_t tail
);

    rd_entry_t stage [RD_LAT];

    // Async clear drops every in-flight read so none returns after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[RD_LAT-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned BE_W   = DATA_W / 8,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [BE_W-1:0]      mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_writedata,
    output logic                 mem_clken,
    input  logic [DATA_W-1:0]    mem_readdata
);

    logic              req0, req1, grant0, grant1, granted;
    owner_e            last_grant;
    logic [ADDR_W-1:0] mux_address;
    logic [BE_W-1:0]   mux_byteenable;
    logic [DATA_W-1:0] mux_writedata;
    logic              mux_read, mux_write, in_range;
    rd_entry_t         push, tail;
    logic [DATA_W-1:0] ret_data;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // On a tie the master that did not win last time is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                grant0 = (last_grant == OWNER_M1);
                grant1 = !grant0;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign granted = grant0 | grant1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWNER_M1;
        end else if (granted) begin
            last_grant <= grant1 ? OWNER_M1 : OWNER_M0;
        end
    end

    always_comb begin
        mux_address    = m0.address;
        mux_byteenable = m0.byteenable;
        mux_writedata  = m0.writedata;
        mux_read       = m0.read;
        mux_write      = m0.write;
        if (grant1) begin
            mux_address    = m1.address;
            mux_byteenable = m1.byteenable;
            mux_writedata  = m1.writedata;
            mux_read       = m1.read;
            mux_write      = m1.write;
        end
    end

    assign in_range       = (32'(mux_address) < DEPTH);
    assign mem_address    = mux_address;
    assign mem_byteenable = mux_byteenable;
    assign mem_writedata  = mux_writedata;
    assign mem_chipselect = granted & in_range;
    assign mem_write      = granted & mux_write & in_range;
    assign mem_clken      = reset_n;

    assign m0.waitrequest = req0 & ~grant0;
    assign m1.waitrequest = req1 & ~grant1;

    // Read+write together is a write, so only a pure read is tracked.
    always_comb begin
        push       = '0;
        push.valid = granted & mux_read & ~mux_write;
        push.owner = grant1 ? OWNER_M1 : OWNER_M0;
        push.oor   = ~in_range;
    end

    onchip_mem_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .tail    (tail)
    );

    assign ret_data = tail.oor ? '0 : mem_readdata;

    assign m0.readdatavalid = tail.valid && (tail.owner == OWNER_M0);
    assign m1.readdatavalid = tail.valid && (tail.owner == OWNER_M1);
    assign m0.readdata      = m0.readdatavalid ? ret_data : '0;
    assign m1.readdata      = m1.readdatavalid ? ret_data : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: two arbiters (RD_LAT 1 and 2) on identical stimulus, each with a RAM model.
module tb_onchip_mem_arbiter;

    localparam int unsigned DEPTH = 51200;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        d0_rd = 0, d0_wr = 0, d1_rd = 0, d1_wr = 0;
    logic [15:0] d0_addr = '0, d1_addr = '0;
    logic [31:0] d0_wd = '0, d1_wd = '0;
    logic [3:0]  d0_be = '0, d1_be = '0;

    onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32), .BE_W(4)) a0 ();
    onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32), .BE_W(4)) a1 ();
    onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32), .BE_W(4)) b0 ();
    onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32), .BE_W(4)) b1 ();

    assign a0.address = d0_addr; assign a0.byteenable = d0_be; assign a0.read = d0_rd;
    assign a0.write = d0_wr;     assign a0.writedata = d0_wd;
    assign b0.address = d0_addr; assign b0.byteenable = d0_be; assign b0.read = d0_rd;
    assign b0.write = d0_wr;     assign b0.writedata = d0_wd;
    assign a1.address = d1_addr; assign a1.byteenable = d1_be; assign a1.read = d1_rd;
    assign a1.write = d1_wr;     assign a1.writedata = d1_wd;
    assign b1.address = d1_addr; assign b1.byteenable = d1_be; assign b1.read = d1_rd;
    assign b1.write = d1_wr;     assign b1.writedata = d1_wd;

    logic [15:0] mem1_address, mem2_address;
    logic [3:0]  mem1_byteenable, mem2_byteenable;
    logic        mem1_chipselect, mem2_chipselect, mem1_write, mem2_write, mem1_clken, mem2_clken;
    logic [31:0] mem1_writedata, mem2_writedata, q1, r2, q2;

    onchip_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .BE_W(4), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .m0(a0), .m1(a1),
        .mem_address(mem1_address), .mem_byteenable(mem1_byteenable),
        .mem_chipselect(mem1_chipselect), .mem_write(mem1_write),
        .mem_writedata(mem1_writedata), .mem_clken(mem1_clken), .mem_readdata(q1));

    onchip_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .BE_W(4), .DEPTH(DEPTH), .RD_LAT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .m0(b0), .m1(b1),
        .mem_address(mem2_address), .mem_byteenable(mem2_byteenable),
        .mem_chipselect(mem2_chipselect), .mem_write(mem2_write),
        .mem_writedata(mem2_writedata), .mem_clken(mem2_clken), .mem_readdata(q2));

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hCAFEF00D;
        if (i == 32) return 32'hFFFFFFFF;
        return 32'h5A5A0000 ^ 32'(i);
    endfunction

    // RAM model; both DUTs issue identical writes so one array serves both.
    logic [31:0] ram [DEPTH];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (mem1_clken && mem1_chipselect && mem1_write) begin
            for (int b = 0; b < 4; b++)
                if (mem1_byteenable[b]) ram[mem1_address][8*b +: 8] <= mem1_writedata[8*b +: 8];
        end
        if (mem1_clken && mem1_chipselect && !mem1_write) q1 <= ram[mem1_address];
        if (mem2_clken && mem2_chipselect && !mem2_write) r2 <= ram[mem2_address];
        q2 <= r2;
    end

    logic [1:0]  o_w0, o_w1, o_v0, o_v1, o_cs, o_we, o_ck;
    logic [31:0] o_d0 [2], o_d1 [2], o_wd [2];
    logic [15:0] o_ad [2];
    logic [3:0]  o_be [2];
    assign o_w0 = {b0.waitrequest, a0.waitrequest};
    assign o_w1 = {b1.waitrequest, a1.waitrequest};
    assign o_v0 = {b0.readdatavalid, a0.readdatavalid};
    assign o_v1 = {b1.readdatavalid, a1.readdatavalid};
    assign o_cs = {mem2_chipselect, mem1_chipselect};
    assign o_we = {mem2_write, mem1_write};
    assign o_ck = {mem2_clken, mem1_clken};
    assign o_d0[0] = a0.readdata; assign o_d0[1] = b0.readdata;
    assign o_d1[0] = a1.readdata; assign o_d1[1] = b1.readdata;
    assign o_wd[0] = mem1_writedata; assign o_wd[1] = mem2_writedata;
    assign o_ad[0] = mem1_address;   assign o_ad[1] = mem2_address;
    assign o_be[0] = mem1_byteenable; assign o_be[1] = mem2_byteenable;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: shadow memory, round-robin rule and a per-cycle table of expected returns.
    logic [31:0] shadow [DEPTH];
    bit          sh_init = 1'b0;
    logic        last_m  = 1'b1;
    logic        pv [2][4];
    logic        po [2][4];
    logic [31:0] pd [2][4];

    always @(negedge clk) begin : compare
        logic r0, r1, g0, g1, w, inr, e0, e1;
        logic [15:0] a;
        int unsigned s;
        if (!sh_init) begin
            for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_word(i);
            for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) pv[k][j] = 1'b0;
            sh_init = 1'b1;
        end
        r0 = d0_rd | d0_wr;
        r1 = d1_rd | d1_wr;
        s  = cyc % 4;
        if (!reset_n) begin
            last_m = 1'b1;
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 4; j++) pv[k][j] = 1'b0;
                chk("rst_wait0", 32'(o_w0[k]), 32'(r0));
                chk("rst_wait1", 32'(o_w1[k]), 32'(r1));
                chk("rst_rdv", 32'({o_v1[k], o_v0[k]}), 32'd0);
                chk("rst_cs_we_ck", 32'({o_cs[k], o_we[k], o_ck[k]}), 32'd0);
                chk("rst_rdata0", o_d0[k], 32'd0);
                chk("rst_rdata1", o_d1[k], 32'd0);
            end
        end else begin
            g0  = r0 && (!r1 || last_m);
            g1  = r1 && !g0;
            w   = g1 ? d1_wr : d0_wr;
            a   = g1 ? d1_addr : d0_addr;
            inr = (32'(a) < DEPTH);
            for (int k = 0; k < 2; k++) begin
                chk("wait0", 32'(o_w0[k]), 32'(r0 && !g0));
                chk("wait1", 32'(o_w1[k]), 32'(r1 && !g1));
                chk("mem_cs", 32'(o_cs[k]), 32'((g0 || g1) && inr));
                chk("mem_we", 32'(o_we[k]), 32'((g0 || g1) && w && inr));
                chk("mem_clken", 32'(o_ck[k]), 32'd1);
                chk("mem_addr", 32'(o_ad[k]), 32'(a));
                if (g0 || g1) chk("mem_be", 32'(o_be[k]), 32'(g1 ? d1_be : d0_be));
                if ((g0 || g1) && w) chk("mem_wdata", o_wd[k], g1 ? d1_wd : d0_wd);
                e0 = pv[k][s] && !po[k][s];
                e1 = pv[k][s] && po[k][s];
                chk("rdv0", 32'(o_v0[k]), 32'(e0));
                chk("rdv1", 32'(o_v1[k]), 32'(e1));
                if (e0) begin chk("rdata0", o_d0[k], pd[k][s]); chk("nonowner1", o_d1[k], 32'd0); end
                if (e1) begin chk("rdata1", o_d1[k], pd[k][s]); chk("nonowner0", o_d0[k], 32'd0); end
                pv[k][s] = 1'b0;
            end
            if (g0 || g1) begin
                last_m = g1;
                if (w) begin
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if ((g1 ? d1_be[b] : d0_be[b]))
                                shadow[a][8*b +: 8] = g1 ? d1_wd[8*b +: 8] : d0_wd[8*b +: 8];
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        pv[k][(cyc + 32'(k) + 1) % 4] = 1'b1;
                        po[k][(cyc + 32'(k) + 1) % 4] = g1;
                        pd[k][(cyc + 32'(k) + 1) % 4] = inr ? shadow[a] : 32'd0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [15:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
        d0_rd = rd; d0_wr = wr; d0_addr = ad; d0_wd = wd; d0_be = be;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [15:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
        d1_rd = rd; d1_wr = wr; d1_addr = ad; d1_wd = wd; d1_be = be;
    endtask

    task automatic idle();
        drv0(0, 0, '0, '0, '0);
        drv1(0, 0, '0, '0, '0);
    endtask

    initial begin
        int nwr;
        reset_n = 1'b0;
        drv0(1, 0, 16'h0010, '0, 4'hF);
        repeat (3) tick();
        reset_n = 1'b1;
        idle();

        // Lone read of 0x0010
        tick(); drv0(1, 0, 16'h0010, '0, 4'hF);
        @(negedge clk); chk("t1_wait", 32'(a0.waitrequest), 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("t1_rdv", 32'(a0.readdatavalid), 32'd1);
        chk("t1_data", a0.readdata, 32'hCAFEF00D);
        chk("t1_m1rdv", 32'(a1.readdatavalid), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_lat2_data", b0.readdata, 32'hCAFEF00D);
        chk("t1_lat2_m1rdv", 32'(b1.readdatavalid), 32'd0);

        // Both masters write continuously right after reset
        tick(); reset_n = 1'b0;
        tick(); tick(); reset_n = 1'b1;
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            drv0(0, 1, 16'h0100 + 16'(i), 32'h10000000 + 32'(i), 4'hF);
            drv1(0, 1, 16'h0200 + 16'(i), 32'h20000000 + 32'(i), 4'hF);
            @(negedge clk);
            chk("t2_wait0", 32'(a0.waitrequest), 32'(i % 2));
            chk("t2_wait1", 32'(a1.waitrequest), 32'((i + 1) % 2));
            if (mem1_chipselect && mem1_write) nwr++;
            tick();
        end
        idle();
        chk("t2_writes", 32'(nwr), 32'd6);

        // Partial write by m1 then read by m0
        drv1(0, 1, 16'h0020, 32'h12345678, 4'h3);
        tick(); idle(); drv0(1, 0, 16'h0020, '0, 4'hF);
        tick(); idle();
        @(negedge clk);
        chk("t3_rdv", 32'(a0.readdatavalid), 32'd1);
        chk("t3_data", a0.readdata, 32'hFFFF5678);

        // Out-of-range write then read
        tick(); drv0(0, 1, 16'd51200, 32'hAAAA5555, 4'hF);
        @(negedge clk);
        chk("t4_wr_cs", 32'(mem1_chipselect), 32'd0);
        chk("t4_wr_wait", 32'(a0.waitrequest), 32'd0);
        tick(); drv0(1, 0, 16'd51200, '0, 4'hF);
        @(negedge clk); chk("t4_rd_cs", 32'(mem1_chipselect), 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("t4_rdv", 32'(a0.readdatavalid), 32'd1);
        chk("t4_data", a0.readdata, 32'd0);

        // Read+write together from m1 acts as a write
        tick(); drv1(1, 1, 16'h0005, 32'h0BADF00D, 4'hF);
        @(negedge clk); chk("t5_we", 32'(mem1_write), 32'd1);
        tick(); idle();
        @(negedge clk); chk("t5_no_rdv", 32'(a1.readdatavalid), 32'd0);
        tick();
        @(negedge clk); chk("t5_no_rdv2", 32'(b1.readdatavalid), 32'd0);
        tick(); drv0(1, 0, 16'h0005, '0, 4'hF);
        tick(); idle();
        @(negedge clk); chk("t5_data", a0.readdata, 32'h0BADF00D);

        // RD_LAT=2 reads cut off by reset, then first tie after release
        tick(); drv0(1, 0, 16'h0010, '0, 4'hF);
        tick(); drv0(1, 0, 16'h0020, '0, 4'hF);
        tick(); idle(); reset_n = 1'b0;
        @(negedge clk); chk("t6_rst_rdv", 32'(b0.readdatavalid), 32'd0);
        tick();
        tick(); reset_n = 1'b1;
        drv0(1, 0, 16'h0030, '0, 4'hF);
        drv1(1, 0, 16'h0040, '0, 4'hF);
        @(negedge clk);
        chk("t6_tie_wait0", 32'(b0.waitrequest), 32'd0);
        chk("t6_tie_wait1", 32'(b1.waitrequest), 32'd1);
        chk("t6_rdv_r0", 32'(b0.readdatavalid), 32'd0);
        tick();
        @(negedge clk); chk("t6_rdv_r1", 32'(b0.readdatavalid), 32'd0);
        repeat (4) tick();

        // Mixed directed traffic, checked by the model
        drv0(1, 0, 16'h0100, '0, 4'hF);           drv1(0, 1, 16'h0010, 32'h11112222, 4'hC); tick();
        drv0(1, 0, 16'h0010, '0, 4'hF);           drv1(1, 0, 16'h0201, '0, 4'hF);           tick();
        drv0(0, 1, 16'h0300, 32'hDEADBEEF, 4'h5); idle_m1();                                tick();
        drv0(1, 0, 16'h0300, '0, 4'hF);           drv1(1, 0, 16'hFFFF, '0, 4'hF);           tick();
        drv0(1, 0, 16'd51199, '0, 4'hF);          drv1(1, 0, 16'h0300, '0, 4'hF);           tick();
        idle();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic idle_m1();
        drv1(0, 0, '0, '0, '0);
    endtask

endmodule
